// File: rtl/sw_pattern_seq.sv
// Switch-pattern capture/playback controller: mirrors synchronised switches onto
// the LEDs, snapshots them into a small store on button presses and replays them.
module sw_pattern_seq #(
  parameter int DEPTH       = 4,
  parameter int TICK_CYCLES = 50_000_000,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       btn_save,
  input  logic       btn_play,
  input  logic       btn_clr,
  output logic [7:0] led,
  output logic [4:0] count,
  output logic [3:0] slot,
  output logic       playing,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [4:0]    DEPTH_C   = 5'(DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);

  typedef enum logic {LIVE, PLAY} state_e;

  logic [7:0]         sw_meta_q, sw_s_q;
  logic [2:0]         btn_raw, btn_meta_q, btn_sync_q, btn_db_q, armed_q, press_q;
  logic [2:0][CW-1:0] db_cnt_q;
  logic [1:0]         settle_q;

  assign btn_raw = {btn_clr, btn_play, btn_save};

  // A button is armed once it has been seen released with valid synchroniser
  // data, so a button held across reset cannot fire until pressed again.
  always_ff @(posedge clk) begin
    // NOTE: every register in a clocked block uses <= so all of them sample
    // pre-edge values; blocking here would create order-dependent logic.
    if (rst) begin
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_db_q   <= '0;
      armed_q    <= '0;
      press_q    <= '0;
      db_cnt_q   <= '0;
      settle_q   <= '0;
    end else begin
      sw_meta_q  <= sw;
      sw_s_q     <= sw_meta_q;
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      for (int b = 0; b < 3; b++) begin
        press_q[b] <= 1'b0;
        if (settle_q == 2'd2 && !btn_sync_q[b]) armed_q[b] <= 1'b1;
        if (btn_sync_q[b] == btn_db_q[b]) begin
          db_cnt_q[b] <= '0;
        end else if (db_cnt_q[b] == DB_LAST) begin
          db_cnt_q[b] <= '0;
          btn_db_q[b] <= ~btn_db_q[b];
          press_q[b]  <= ~btn_db_q[b] & armed_q[b];
        end else begin
          db_cnt_q[b] <= db_cnt_q[b] + CW'(1);
        end
      end
    end
  end

  // Only the highest-priority pulse acts: clr > play > save.
  logic clr_p, play_p, save_p;
  assign clr_p  = press_q[2];
  assign play_p = press_q[1] & ~press_q[2];
  assign save_p = press_q[0] & ~press_q[1] & ~press_q[2];

  state_e        state_q;
  logic [7:0]    led_q;
  logic [4:0]    count_q;
  logic [3:0]    slot_q, slot_d;
  logic [TW-1:0] tick_q;
  logic [7:0]    store_q [DEPTH];
  logic          store_we;

  always_comb begin
    slot_d   = ({1'b0, slot_q} == count_q - 5'd1) ? 4'd0 : slot_q + 4'd1;
    store_we = (state_q == LIVE) && save_p && (count_q < DEPTH_C);
  end

  // NOTE: the pattern store has no reset; slots at or above count are never
  // read, so clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (store_we) store_q[count_q[AW-1:0]] <= sw_s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LIVE;
      led_q   <= '0;
      count_q <= '0;
      slot_q  <= '0;
      tick_q  <= '0;
    end else begin
      case (state_q)
        LIVE: begin
          led_q <= sw_s_q;
          if (clr_p) begin
            count_q <= '0;
          end else if (play_p) begin
            if (count_q != 5'd0) begin
              state_q <= PLAY;
              slot_q  <= '0;
              tick_q  <= '0;
              led_q   <= store_q[0];
            end
          end else if (save_p && count_q < DEPTH_C) begin
            count_q <= count_q + 5'd1;
          end
        end
        PLAY: begin
          if (clr_p || play_p) begin
            state_q <= LIVE;
            slot_q  <= '0;
            tick_q  <= '0;
            if (clr_p) count_q <= '0;
          end else if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            slot_q <= slot_d;
            led_q  <= store_q[slot_d[AW-1:0]];
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: state_q <= LIVE;
      endcase
    end
  end

  assign led     = led_q;
  assign count   = count_q;
  assign slot    = slot_q;
  assign playing = (state_q == PLAY);
  assign full    = (count_q == DEPTH_C);

endmodule

// File: doc/sw_pattern_seq.md
# sw_pattern_seq

Switch-pattern capture and playback controller that sequences the 8-bit switch-to-LED register path on the board. In LIVE mode it mirrors the synchronised switches onto the LEDs. Debounced buttons snapshot the switches into a small pattern store and start or stop timed playback of the stored patterns. It sits between the raw board I/O (switches, push-buttons) and the LED bank.

## Interface
- DEPTH, 4: number of pattern slots; power of two, 2..16.
- TICK_CYCLES, 50_000_000: clk cycles each pattern is shown during playback; ≥2.
- DB_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change; ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  8  raw switch inputs, asynchronous.
- btn_save  in  1  raw push-button, asynchronous, high = pressed.
- btn_play  in  1  raw push-button, toggles playback.
- btn_clr  in  1  raw push-button, clears the store.
- led  out  8  registered LED drive.
- count  out  5  number of stored patterns, 0..DEPTH.
- slot  out  4  current playback slot index.
- playing  out  1  high in PLAY state.
- full  out  1  high when count == DEPTH (combinational from count).

## Operation
- Input conditioning:
  - sw passes through a 2-flop synchroniser, giving sw_s.
  - Each button passes through a 2-flop synchroniser, then a debouncer.
  - Debouncer counter: resets to 0 whenever the synced level equals the debounced level. Otherwise it increments.
  - When the counter reaches DB_CYCLES, the debounced level flips and the counter clears.
  - A one-cycle press pulse is generated on each debounced 0→1 transition. Releases generate nothing.
- Store: DEPTH × 8 register array, written at index count. Contents are not reset. Slots ≥ count are never read.
- FSM states: LIVE (reset state) and PLAY.
- Pulse priority in any cycle: clr > play > save. Only the highest-priority pulse acts.
- LIVE:
  - led <= sw_sync every cycle.
  - save pulse: if count < DEPTH, store[count] <= sw_s and count++. If full, the pulse is ignored and nothing changes.
  - play pulse: if count == 0, ignored and the FSM stays in LIVE. Otherwise go to PLAY with slot <= 0, tick <= 0, led <= store[0].
  - clr pulse: count <= 0. led keeps tracking sw_s.
- PLAY:
  - tick increments each cycle.
  - When tick == TICK_CYCLES-1: tick <= 0, slot <= (slot == count-1) ? 0 : slot+1, led <= store[new slot].
  - With count == 1, led holds store[0] permanently.
  - play pulse: go to LIVE, slot <= 0, tick <= 0. led resumes tracking sw_s from the next cycle.
  - clr pulse: count <= 0, go to LIVE, slot <= 0, tick <= 0.
  - save pulse: ignored.
- playing = (state == PLAY), registered with the state.

## Timing
- Reset (rst high at an edge): led=0, count=0, slot=0, playing=0, full=0, tick=0, FSM=LIVE.
  - Synchronisers and debounced levels clear to 0; debounce counters clear to 0.
  - Reset mid-playback or mid-debounce aborts immediately. No pulse is generated for a button still held across reset release until it is released and pressed again.
- sw → led in LIVE: a change sampled at edge k is visible on led after edge k+2 (two synchroniser stages plus the output register).
- Button latency: raw input rises before edge k and is held.
  - Synced high after edge k+1.
  - Debounced level and press pulse rise after edge k+1+DB_CYCLES.
  - The action (count, led, state) is visible after edge k+2+DB_CYCLES.
- Bounce: any return to the old synced level before DB_CYCLES is reached restarts the count from 0.
- Playback: after entering PLAY, each slot is shown for exactly TICK_CYCLES cycles. Wrap from slot count-1 to slot 0 takes no extra cycle.
- Only one press pulse per debounced press, however long the button is held.

## Test plan
All scenarios use DEPTH=4, TICK_CYCLES=8, DB_CYCLES=4.
- Reset/live:
  - Stimulus: assert rst 2 cycles, then sw=8'hA5.
  - Required: all outputs are 0 during reset; led=8'hA5 exactly 2 edges after sw is sampled; playing=0.
- Capture and full:
  - Stimulus: store sw=11, 22, 33, 44, 55 with clean presses.
  - Required: count steps 1..4; full=1 after the 4th press; 5th press leaves count=4 and store unchanged.
- Playback and wrap:
  - Stimulus: after capture, press play.
  - Required: playing=1; led shows 11, 22, 33, 44, 11, 22, each held 8 cycles; slot shows 0, 1, 2, 3, 0.
  - Stimulus: press play again.
  - Required: playing=0, led=sw_s, slot=0.
- Bounce rejection:
  - Stimulus: toggle btn_save high 3 cycles / low 1 cycle, repeated, then hold high 10 cycles.
  - Required: count increments exactly once, at DB_CYCLES+2 edges after the final sustained rise.
- Empty play and priority:
  - Stimulus: with count=0, press play.
  - Required: playing stays 0.
  - Stimulus: with count=2, assert clr and play so their pulses coincide.
  - Required: count=0, playing=0.
- Reset mid-playback:
  - Stimulus: assert rst at slot=2 while btn_play is still held.
  - Required: all outputs are 0; no new PLAY entry until btn_play is released and pressed again (and then ignored, since count=0).
